// File: rtl/mmio_router_pkg.sv
// Shared types, widths and default constants for the MMIO CSR router
// and its address decoder.
package mmio_router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } t_rtr_state;

  // Where the upstream read response comes from.
  typedef enum logic [1:0] {
    RSP_MAPPED   = 2'd0,
    RSP_STATUS   = 2'd1,
    RSP_UNMAPPED = 2'd2,
    RSP_TIMEOUT  = 2'd3
  } t_rsp_src;

  localparam int CNT_W      = 32;
  localparam int PORT_IDX_W = 3;

  localparam logic [17:0] DEF_STATUS_ADDR   = 18'h3FFFE;
  localparam logic [63:0] DEF_UNMAPPED_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DEF_TIMEOUT_DATA  = 64'hDEAD_DEAD_DEAD_DEAD;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/mmio_csr_router_if.sv
// Bus bundle for the router: upstream AVMM slave side plus the packed
// per-port downstream AVMM master side.
interface mmio_csr_router_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 64
);
  logic [ADDR_W-1:0]             avmm_address;
  logic                          avmm_read;
  logic                          avmm_write;
  logic [DATA_W-1:0]             avmm_writedata;
  logic [DATA_W/8-1:0]           avmm_byteenable;
  logic                          avmm_waitrequest;
  logic [DATA_W-1:0]             avmm_readdata;
  logic                          avmm_readdatavalid;

  logic [NUM_PORTS*ADDR_W-1:0]   dn_address;
  logic [NUM_PORTS-1:0]          dn_read;
  logic [NUM_PORTS-1:0]          dn_write;
  logic [NUM_PORTS*DATA_W-1:0]   dn_writedata;
  logic [NUM_PORTS*DATA_W/8-1:0] dn_byteenable;
  logic [NUM_PORTS-1:0]          dn_waitrequest;
  logic [NUM_PORTS*DATA_W-1:0]   dn_readdata;
  logic [NUM_PORTS-1:0]          dn_readdatavalid;

  // Router view.
  modport slave (
    input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
           dn_waitrequest, dn_readdata, dn_readdatavalid,
    output avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
           dn_address, dn_read, dn_write, dn_writedata, dn_byteenable
  );

  // Environment view: upstream bridge plus downstream CSR slaves.
  modport master (
    output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
           dn_waitrequest, dn_readdata, dn_readdatavalid,
    input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
           dn_address, dn_read, dn_write, dn_writedata, dn_byteenable
  );
endinterface

// File: rtl/mmio_csr_router_decode.sv
// Combinational priority address decoder: status register first, then the
// lowest-numbered port whose masked address matches its base.
module mmio_addr_decode
  import mmio_router_pkg::*;
#(
  parameter int                          NUM_PORTS   = 4,
  parameter int                          ADDR_W      = 18,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_BASE   = '0,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_MASK   = '0,
  parameter logic [ADDR_W-1:0]           STATUS_ADDR = ADDR_W'(DEF_STATUS_ADDR)
) (
  input  logic [ADDR_W-1:0]     address,
  output logic                  hit,
  output logic [PORT_IDX_W-1:0] port_idx,
  output logic                  is_status
);

  // Walk from the highest port down so the lowest matching index wins.
  always_comb begin
    hit       = 1'b0;
    port_idx  = '0;
    is_status = (address == STATUS_ADDR);
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((address & PORT_MASK[i*ADDR_W +: ADDR_W]) == PORT_BASE[i*ADDR_W +: ADDR_W]) begin
        hit      = 1'b1;
        port_idx = PORT_IDX_W'(i);
      end else begin
        hit      = hit;
        port_idx = port_idx;
      end
    end
  end

endmodule

// File: rtl/mmio_csr_router.sv
// MMIO fabric from the upstream AVMM bridge to NUM_PORTS downstream CSR
// slaves: one transaction in flight, timeout, unmapped handling, error status.
module mmio_csr_router
  import mmio_router_pkg::*;
#(
  parameter int                          NUM_PORTS      = 4,
  parameter int                          ADDR_W         = 18,
  parameter int                          DATA_W         = 64,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_BASE      = '0,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_MASK      = '0,
  parameter logic [ADDR_W-1:0]           STATUS_ADDR    = ADDR_W'(DEF_STATUS_ADDR),
  parameter int                          TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]           UNMAPPED_DATA  = DATA_W'(DEF_UNMAPPED_DATA),
  parameter logic [DATA_W-1:0]           TIMEOUT_DATA   = DATA_W'(DEF_TIMEOUT_DATA)
) (
  input logic              clk,
  input logic              reset,
  mmio_csr_router_if.slave bus
);

  localparam int                BE_W    = DATA_W / 8;
  localparam int                TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  t_rtr_state                  state_r, next_state_s;
  t_rsp_src                    rsp_src_r;
  logic                        waitrequest_r;
  logic [ADDR_W-1:0]           cmd_addr_r;
  logic [DATA_W-1:0]           cmd_wdata_r;
  logic [BE_W-1:0]             cmd_be_r;
  logic                        cmd_rd_r;
  logic [PORT_IDX_W-1:0]       sel_port_r;
  logic [NUM_PORTS-1:0]        dn_read_r, dn_write_r;
  logic [TO_W-1:0]             to_cnt_r;
  logic [CNT_W-1:0]            timeout_cnt_r, unmapped_cnt_r;
  logic [DATA_W-1:0]           readdata_r;
  logic                        readdatavalid_r;

  logic                        hit_s, is_status_s;
  logic [PORT_IDX_W-1:0]       port_idx_s;
  logic [NUM_PORTS-1:0]        port_onehot_s;
  logic                        sel_wait_s, sel_rdv_s;
  logic [DATA_W-1:0]           sel_rdata_s, local_data_s;
  logic [NUM_PORTS*ADDR_W-1:0] dn_address_s;
  logic                        accept_s, issue_start_s, to_expired_s;
  logic                        capture_s, local_load_s, timeout_s;
  logic                        unmapped_inc_s, status_clear_s;

  mmio_addr_decode #(
    .NUM_PORTS  (NUM_PORTS),
    .ADDR_W     (ADDR_W),
    .PORT_BASE  (PORT_BASE),
    .PORT_MASK  (PORT_MASK),
    .STATUS_ADDR(STATUS_ADDR)
  ) u_decode (
    .address  (bus.avmm_address),
    .hit      (hit_s),
    .port_idx (port_idx_s),
    .is_status(is_status_s)
  );

  // Port selection: one-hot of the decoded port and mux of the latched port's responses.
  always_comb begin
    port_onehot_s = '0;
    sel_wait_s    = 1'b1;
    sel_rdv_s     = 1'b0;
    sel_rdata_s   = '0;
    dn_address_s  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_onehot_s[i] = (port_idx_s == PORT_IDX_W'(i));
      sel_wait_s  = (sel_port_r == PORT_IDX_W'(i)) ? bus.dn_waitrequest[i] : sel_wait_s;
      sel_rdv_s   = (sel_port_r == PORT_IDX_W'(i)) ? bus.dn_readdatavalid[i] : sel_rdv_s;
      sel_rdata_s = (sel_port_r == PORT_IDX_W'(i)) ? bus.dn_readdata[i*DATA_W +: DATA_W] : sel_rdata_s;
      dn_address_s[i*ADDR_W +: ADDR_W] = cmd_addr_r & ~PORT_MASK[i*ADDR_W +: ADDR_W];
    end
  end

  // Transaction-level strobes derived from the current state and upstream request.
  always_comb begin
    accept_s       = (state_r == IDLE) && !waitrequest_r && (bus.avmm_read || bus.avmm_write);
    issue_start_s  = accept_s && hit_s && !is_status_s;
    unmapped_inc_s = accept_s && !is_status_s && !hit_s;
    status_clear_s = accept_s && is_status_s && bus.avmm_write && !bus.avmm_read;
    to_expired_s   = (to_cnt_r == TO_LAST);
  end

  // Next-state logic; a completing slave beats a simultaneous timeout.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    local_load_s = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = (is_status_s || !hit_s) ? RESP : ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!sel_wait_s) begin
          if (!cmd_rd_r) begin
            next_state_s = IDLE;
          end else if (sel_rdv_s) begin
            capture_s    = 1'b1;
            next_state_s = RESP;
          end else begin
            next_state_s = RD_WAIT;
          end
        end else if (to_expired_s) begin
          timeout_s    = 1'b1;
          next_state_s = cmd_rd_r ? RESP : IDLE;
        end else begin
          next_state_s = ISSUE;
        end
      end
      RD_WAIT: begin
        if (sel_rdv_s) begin
          capture_s    = 1'b1;
          next_state_s = RESP;
        end else if (to_expired_s) begin
          timeout_s    = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = RD_WAIT;
        end
      end
      RESP: begin
        // Locally sourced reads spend one cycle here loading the response first.
        if (readdatavalid_r) begin
          next_state_s = IDLE;
        end else if (cmd_rd_r) begin
          local_load_s = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and upstream stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      waitrequest_r <= 1'b1;
    end else begin
      state_r       <= next_state_s;
      waitrequest_r <= (next_state_s != IDLE);
    end
  end

  // Command capture on accept; a simultaneous read and write is treated as a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_addr_r  <= '0;
      cmd_wdata_r <= '0;
      cmd_be_r    <= '0;
      cmd_rd_r    <= 1'b0;
      sel_port_r  <= '0;
      rsp_src_r   <= RSP_MAPPED;
    end else if (accept_s) begin
      cmd_addr_r  <= bus.avmm_address;
      cmd_wdata_r <= bus.avmm_writedata;
      cmd_be_r    <= bus.avmm_byteenable;
      cmd_rd_r    <= bus.avmm_read;
      sel_port_r  <= port_idx_s;
      rsp_src_r   <= is_status_s ? RSP_STATUS : (hit_s ? RSP_MAPPED : RSP_UNMAPPED);
    end else if (timeout_s) begin
      rsp_src_r   <= RSP_TIMEOUT;
    end
  end

  // Downstream request strobes, held for the whole ISSUE phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      dn_read_r  <= '0;
      dn_write_r <= '0;
    end else if (issue_start_s) begin
      dn_read_r  <= port_onehot_s & {NUM_PORTS{bus.avmm_read}};
      dn_write_r <= port_onehot_s & {NUM_PORTS{bus.avmm_write & ~bus.avmm_read}};
    end else if ((state_r == ISSUE) && (next_state_s != ISSUE)) begin
      dn_read_r  <= '0;
      dn_write_r <= '0;
    end
  end

  // Per-transaction timeout counter.
  always_ff @(posedge clk) begin
    if (reset || accept_s) begin
      to_cnt_r <= '0;
    end else if (((state_r == ISSUE) || (state_r == RD_WAIT)) && !to_expired_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Saturating error counters; a status write clears both and wins over increments.
  always_ff @(posedge clk) begin
    if (reset || status_clear_s) begin
      timeout_cnt_r  <= '0;
      unmapped_cnt_r <= '0;
    end else begin
      if (timeout_s) begin
        timeout_cnt_r <= sat_inc(timeout_cnt_r);
      end
      if (unmapped_inc_s) begin
        unmapped_cnt_r <= sat_inc(unmapped_cnt_r);
      end
    end
  end

  // Read data for responses generated inside the router.
  always_comb begin
    local_data_s = UNMAPPED_DATA;
    case (rsp_src_r)
      RSP_STATUS:   local_data_s = DATA_W'({timeout_cnt_r, unmapped_cnt_r});
      RSP_TIMEOUT:  local_data_s = TIMEOUT_DATA;
      RSP_UNMAPPED: local_data_s = UNMAPPED_DATA;
      default:      local_data_s = UNMAPPED_DATA;
    endcase
  end

  // Upstream response register; readdatavalid is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r      <= '0;
      readdatavalid_r <= 1'b0;
    end else if (capture_s) begin
      readdata_r      <= sel_rdata_s;
      readdatavalid_r <= 1'b1;
    end else if (local_load_s) begin
      readdata_r      <= local_data_s;
      readdatavalid_r <= 1'b1;
    end else begin
      readdatavalid_r <= 1'b0;
    end
  end

  assign bus.avmm_waitrequest   = waitrequest_r;
  assign bus.avmm_readdata      = readdata_r;
  assign bus.avmm_readdatavalid = readdatavalid_r;
  assign bus.dn_address         = dn_address_s;
  assign bus.dn_read            = dn_read_r;
  assign bus.dn_write           = dn_write_r;
  assign bus.dn_writedata       = {NUM_PORTS{cmd_wdata_r}};
  assign bus.dn_byteenable      = {NUM_PORTS{cmd_be_r}};

endmodule
